// File: rtl/skew_delay_line.sv
// Multi-channel programmable delay line with optional diagonal skew (channel c gets +c cycles),
// per-sample valid tracking, stall, flush and a busy-guarded configuration register.
module skew_delay_line #(
  parameter int DW_DATA   = 8,
  parameter int N_CH      = 4,
  parameter int MAX_DEPTH = 16,
  parameter int W_DEPTH   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_load,
  input  logic [W_DEPTH-1:0]        cfg_depth,
  input  logic                      cfg_skew_en,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*DW_DATA-1:0]   in_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic [N_CH-1:0]           out_valid,
  output logic [N_CH*DW_DATA-1:0]   out_data,
  output logic                      busy
);

  localparam int S     = MAX_DEPTH + N_CH - 1;
  localparam int W_IDX = (S > 1) ? $clog2(S) : 1;

  logic [DW_DATA-1:0] data_q [N_CH][S];
  logic [DW_DATA-1:0] data_d [N_CH][S];
  logic [S-1:0]       vld_q  [N_CH];
  logic [S-1:0]       vld_d  [N_CH];

  logic [W_DEPTH-1:0] cfg_depth_q, cfg_depth_d;
  logic               skew_en_q, skew_en_d;
  logic               cfg_err_q, cfg_err_d;

  int                 deff;
  int                 tap_int [N_CH];
  logic [W_IDX-1:0]   tap_idx [N_CH];
  logic               busy_w;

  // Effective depth is clamped to [1, MAX_DEPTH]; each channel taps stage L_c-1.
  always_comb begin
    deff = int'(cfg_depth_q);
    if (deff < 1) begin
      deff = 1;
    end else if (deff > MAX_DEPTH) begin
      deff = MAX_DEPTH;
    end
    for (int c = 0; c < N_CH; c++) begin
      tap_int[c] = deff - 1 + (skew_en_q ? c : 0);
      tap_idx[c] = W_IDX'(tap_int[c]);
    end
  end

  always_comb begin
    busy_w = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      busy_w = busy_w | (|vld_q[c]);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (flush) begin
      for (int c = 0; c < N_CH; c++) begin
        vld_d[c] = '0;
      end
    end else if (!stall) begin
      for (int c = 0; c < N_CH; c++) begin
        data_d[c][0] = in_valid ? in_data[c*DW_DATA +: DW_DATA] : '0;
        vld_d[c][0]  = in_valid;
        for (int j = 1; j < S; j++) begin
          data_d[c][j] = data_q[c][j-1];
          // Flags are dropped once a sample moves past its channel's tap, so busy
          // falls as soon as the last sample has been presented.
          vld_d[c][j]  = vld_q[c][j-1] && (j <= tap_int[c]);
        end
      end
    end
  end

  always_comb begin
    cfg_depth_d = cfg_depth_q;
    skew_en_d   = skew_en_q;
    cfg_err_d   = cfg_load & busy_w;
    if (cfg_load && !busy_w) begin
      cfg_depth_d = cfg_depth;
      skew_en_d   = cfg_skew_en;
    end
  end

  // NOTE: the data stages are reset too, because out_data and the stage contents must read as zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '{default: '0};
      vld_q       <= '{default: '0};
      cfg_depth_q <= W_DEPTH'(1);
      skew_en_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      vld_q       <= vld_d;
      cfg_depth_q <= cfg_depth_d;
      skew_en_q   <= skew_en_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!stall && vld_q[c][tap_idx[c]]) begin
        out_valid[c]                    = 1'b1;
        out_data[c*DW_DATA +: DW_DATA]  = data_q[c][tap_idx[c]];
      end
    end
  end

  assign in_ready = ~stall;
  assign busy     = busy_w;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_skew_delay_line.sv
// Self-checking bench for skew_delay_line: directed scenarios plus random traffic, all checked
// against a queue model that tracks how many advances each accepted sample has seen.
module tb_skew_delay_line;
  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int MAXD = 16;
  localparam int WD   = 5;

  logic              clk;
  logic              reset;
  logic              cfg_load;
  logic [WD-1:0]     cfg_depth;
  logic              cfg_skew_en;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              stall;
  logic              flush;
  logic [NCH-1:0]    out_valid;
  logic [NCH*DW-1:0] out_data;
  logic              busy;

  skew_delay_line #(.DW_DATA(DW), .N_CH(NCH), .MAX_DEPTH(MAXD), .W_DEPTH(WD)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_depth(cfg_depth),
    .cfg_skew_en(cfg_skew_en), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted sample remembers the advance count at which it entered;
  // its distance travelled is (adv - a), and it shows on lane c when that equals L_c-1.
  typedef struct {
    logic [31:0] d;
    int          a;
  } ent_t;

  ent_t          mq[$];
  int            adv;
  logic [WD-1:0] m_depth;
  logic          m_skew;
  logic          exp_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [NCH-1:0] obs_valid;
  logic [31:0]    obs_data;
  logic           obs_busy;
  logic           obs_err;

  function automatic int m_deff();
    int d;
    d = int'(m_depth);
    if (d < 1) d = 1;
    if (d > MAXD) d = MAXD;
    return d;
  endfunction

  function automatic int m_lat(input int c);
    return m_deff() + (m_skew ? c : 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    adv     = 0;
    m_depth = WD'(1);
    m_skew  = 1'b0;
    exp_err = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, update the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] dat, input logic st, input logic fl,
                      input logic cl, input logic [WD-1:0] cd, input logic cs);
    logic [NCH-1:0] ev;
    logic [31:0]    ed;
    logic           eb;
    ent_t           e;
    in_valid    = v;
    in_data     = dat;
    stall       = st;
    flush       = fl;
    cfg_load    = cl;
    cfg_depth   = cd;
    cfg_skew_en = cs;
    #1;
    ev = '0;
    ed = '0;
    if (!st) begin
      foreach (mq[i]) begin
        for (int c = 0; c < NCH; c++) begin
          if (adv - mq[i].a == m_lat(c) - 1) begin
            ev[c]         = 1'b1;
            ed[c*DW +: DW] = mq[i].d[c*DW +: DW];
          end
        end
      end
    end
    eb = (mq.size() != 0);
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_busy  = busy;
    obs_err   = cfg_err;
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
    end
    checks++;
    if (out_data !== ed) begin
      errors++;
      $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, ed);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
    checks++;
    if (in_ready !== !st) begin
      errors++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !st);
    end
    checks++;
    if (cfg_err !== exp_err) begin
      errors++;
      $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, exp_err);
    end
    @(posedge clk);
    exp_err = cl && eb;
    if (cl && !eb) begin
      m_depth = cd;
      m_skew  = cs;
    end
    if (fl) begin
      mq.delete();
    end else if (!st) begin
      adv++;
      if (v) begin
        e.d = dat;
        e.a = adv;
        mq.push_back(e);
      end
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (adv - mq[i].a > m_lat(NCH-1) - 1) mq.delete(i);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic cfg(input logic [WD-1:0] d, input logic s);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, d, s);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && busy; k++) idle();
  endtask

  // Sends one sample and reports how many cycles later lane `lane` shows it.
  task automatic measure_lat(input string name, input int lane, input int exp_lat);
    int got;
    got = -1;
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 40 && got < 0; k++) begin
      idle();
      if (obs_valid[lane]) got = k;
    end
    checks++;
    if (got != exp_lat) begin
      errors++;
      $display("FAIL %s lane=%0d latency got=%0d exp=%0d", name, lane, got, exp_lat);
    end
    drain();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== '0 || out_data !== '0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h b=%b e=%b exp all zero", out_valid, out_data, busy, cfg_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    measure_lat("default_lat", 0, 1);
    measure_lat("default_lat", 3, 1);
  endtask

  task automatic test_basic();
    int first;
    logic b3, b4;
    first = -1;
    b3 = 1'b0;
    b4 = 1'b1;
    cfg(WD'(3), 1'b0);
    idle();
    step(1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (first < 0 && obs_valid == 4'b1111 && obs_data == 32'h11223344) first = k;
      if (k == 3) b3 = obs_busy;
      if (k == 4) b4 = obs_busy;
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=3", first);
    end
    checks++;
    if (b3 !== 1'b1 || b4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_drop got=%b%b exp=10", b3, b4);
    end
  endtask

  task automatic test_skew();
    logic [31:0] sd [5];
    int first [NCH];
    int last  [NCH];
    int cnt   [NCH];
    int bad;
    bad = 0;
    for (int i = 0; i < 5; i++) sd[i] = $urandom;
    for (int c = 0; c < NCH; c++) begin
      first[c] = -1;
      last[c]  = -1;
      cnt[c]   = 0;
    end
    cfg(WD'(2), 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (k < 5) step(1'b1, sd[k], 1'b0, 1'b0, 1'b0, '0, 1'b0);
      else idle();
      for (int c = 0; c < NCH; c++) begin
        if (obs_valid[c]) begin
          if (first[c] < 0) first[c] = k;
          last[c] = k;
          if (cnt[c] < 5 && obs_data[c*DW +: DW] != sd[cnt[c]][c*DW +: DW]) bad++;
          cnt[c]++;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (first[c] != 2 + c || last[c] != 6 + c || cnt[c] != 5) begin
        errors++;
        $display("FAIL skew_lane%0d got first=%0d last=%0d cnt=%0d exp first=%0d last=%0d cnt=5",
                 c, first[c], last[c], cnt[c], 2 + c, 6 + c);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL skew_order got=%0d wrong samples exp=0", bad);
    end
  endtask

  task automatic test_stall();
    logic [31:0] sd [4];
    int hits [2];
    int n;
    n = 0;
    hits[0] = -1;
    hits[1] = -1;
    for (int i = 0; i < 4; i++) sd[i] = $urandom;
    cfg(WD'(4), 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(k <= 3, (k <= 3) ? sd[k % 4] : 32'h0, (k >= 2 && k <= 4), 1'b0, 1'b0, '0, 1'b0);
      if (obs_valid != '0) begin
        if (n < 2 && obs_valid == 4'b1111 && obs_data == sd[n]) hits[n] = k;
        n++;
      end
    end
    checks++;
    if (n != 2 || hits[0] != 7 || hits[1] != 8) begin
      errors++;
      $display("FAIL stall_exit got n=%0d at %0d,%0d exp n=2 at 7,8", n, hits[0], hits[1]);
    end
  endtask

  task automatic test_flush_guard();
    int nval;
    int nerr;
    int first;
    logic b6;
    nval = 0;
    b6 = 1'b1;
    cfg(WD'(8), 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(k <= 2, $urandom, 1'b0, k == 5, 1'b0, '0, 1'b0);
      if (obs_valid != '0) nval++;
      if (k == 6) b6 = obs_busy;
    end
    checks++;
    if (nval != 0 || b6 !== 1'b0) begin
      errors++;
      $display("FAIL flush got valids=%0d busy_after=%b exp 0,0", nval, b6);
    end
    nerr = 0;
    first = -1;
    cfg(WD'(5), 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k == 0) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      else if (k == 1) cfg(WD'(2), 1'b1);
      else idle();
      if (obs_err) nerr++;
      if (first < 0 && obs_valid == 4'b1111) first = k;
    end
    checks++;
    if (nerr != 1) begin
      errors++;
      $display("FAIL cfg_err_pulses got=%0d exp=1", nerr);
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL guard_latency got=%0d exp=5", first);
    end
    measure_lat("guard_kept", 3, 5);
  endtask

  task automatic test_clamp();
    cfg(WD'(0), 1'b0);
    measure_lat("clamp_zero", 0, 1);
    cfg(WD'(31), 1'b0);
    measure_lat("clamp_max", 0, 16);
    cfg(WD'(16), 1'b1);
    measure_lat("skew_max", 3, 19);
  endtask

  task automatic test_random();
    logic cl, v, st, fl;
    for (int k = 0; k < 800; k++) begin
      cl = ($urandom_range(0, 14) == 0);
      v  = !cl && ($urandom_range(0, 9) < 5);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 39) == 0);
      step(v, $urandom, st, fl, cl, WD'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < 22; j++) idle();
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    cfg(WD'(16), 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 4'b1111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prereset_full got v=%b b=%b exp 1111,1", out_valid, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== '0 || out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b d=%h b=%b exp zero", out_valid, out_data, busy);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    measure_lat("post_reset", 0, 1);
    measure_lat("post_reset", 3, 1);
  endtask

  initial begin
    reset       = 1'b1;
    cfg_load    = 1'b0;
    cfg_depth   = '0;
    cfg_skew_en = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    stall       = 1'b0;
    flush       = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_skew();
    test_stall();
    test_flush_guard();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_delay_line.md
# skew_delay_line

- Multi-channel, runtime-programmable delay line with per-sample valid tracking.
- Optional diagonal skew: channel c gets c extra cycles, for feeding and draining the systolic PE array.
- Replaces fixed single-channel delay stages between the operand buffers and the array.
- Adds pipeline stall, flush, and guarded reconfiguration.

## Interface
Parameters:
- DW_DATA, 8, bits per channel sample
- N_CH, 4, number of channels (≥1)
- MAX_DEPTH, 16, largest programmable base delay (≥1)
- W_DEPTH, 5, width of cfg_depth; must hold MAX_DEPTH

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- cfg_load  in  1  request to latch cfg_depth/cfg_skew_en
- cfg_depth  in  W_DEPTH  requested base delay D
- cfg_skew_en  in  1  1 = channel c gets +c cycles
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- in_valid  in  1  sample present on in_data (all channels together)
- in_ready  out  1  = ~stall
- in_data  in  N_CH*DW_DATA  channel c at bits [c*DW_DATA +: DW_DATA]
- stall  in  1  freeze entire pipeline
- flush  in  1  discard all in-flight samples
- out_valid  out  N_CH  per-channel valid
- out_data  out  N_CH*DW_DATA  per-channel data, same packing as in_data
- busy  out  1  any valid sample in flight

## Operation
- Storage: per channel, a shift chain of S = MAX_DEPTH+N_CH-1 stages. Each stage holds data and a valid flag.
- Effective base delay Deff = clamp(cfg_depth_reg, 1, MAX_DEPTH). A value of 0 acts as 1; values above MAX_DEPTH act as MAX_DEPTH.
- Channel latency: L_c = Deff + (skew_en_reg ? c : 0). Output tap for channel c is stage L_c-1.
- Advance condition: an advance occurs on every edge with stall=0 and flush=0.
  - stage[0] <= in_valid ? in_data : 0; flag[0] <= in_valid.
  - stage[j] <= stage[j-1] for j ≥ 1.
- Accept: a sample is accepted iff in_valid & in_ready. With stall=1, in_valid is ignored and the sample is lost; upstream must honour in_ready.
- Stall (flush=0): all stages and flags hold. out_valid is forced to all-zero while stall=1. out_data is forced to 0 while stall=1.
- Flush: clears every valid flag on that edge. Data contents are don't-care.
  - flush has priority over stall and in_valid.
  - A sample presented in the same cycle as flush is discarded.
- out_data lane c = tap data when the tap flag is 1 and stall=0; otherwise 0.
- busy = OR of all valid flags in all channels and stages.
- Configuration: cfg_depth_reg and skew_en_reg update on an edge with cfg_load=1 and busy=0.
  - With busy=1, cfg_load is ignored and cfg_err=1 for the following cycle. Registers are unchanged.
  - New config applies to samples accepted from the next cycle on.
  - cfg_load in the same cycle as flush: flush clears the flags and the config is still evaluated against the pre-edge busy.
- Reset values:
  - all flags 0, all data 0
  - cfg_depth_reg = 1, skew_en_reg = 0
  - out_valid = 0, out_data = 0, busy = 0, cfg_err = 0
  - in_ready = ~stall (combinational)
- Reset mid-operation: all in-flight samples are dropped immediately (asynchronous) and config returns to default.

## Timing
- Sample accepted in cycle n appears on channel c in cycle n + L_c + (number of stall cycles in between). out_valid[c]=1 for exactly one cycle per sample.
- Back-to-back accepts produce back-to-back outputs, one per cycle per channel. There are no bubbles unless stalled.
- Skew mode: one accepted sample emerges on channels 0..N_CH-1 in consecutive cycles.
- The outputs are combinational from the tap registers and stall. There is no extra output register.
- cfg_err is registered: one cycle after the rejected cfg_load.
- Latency bounds: minimum 1 (D ≤ 1, no skew). Maximum MAX_DEPTH + N_CH - 1.

## Test plan
- **Basic latency.** Defaults (N_CH=4, MAX_DEPTH=16). cfg D=3, skew=0. Send one sample 0x11223344 in cycle 10 → all out_valid=4'b1111 in cycle 13 with the same data. busy deasserts in cycle 14.
- **Skew mode.** D=2, skew=1. Stream 5 consecutive samples → lane c's first valid output in cycle start+2+c. Each lane emits 5 valid outputs in 5 consecutive cycles, in order.
- **Stall.** D=4. Send samples in cycles 0..3, stall=1 in cycles 2..4 → inputs in cycles 2..3 are dropped (in_ready=0). No out_valid during the stall. Samples 0 and 1 exit in cycles 7 and 8.
- **Flush and config guard.**
  - D=8, 3 samples in flight, pulse flush → out_valid never asserts and busy=0 next cycle.
  - cfg_load while busy → cfg_err pulses once and latency stays unchanged.
- **Clamp and boundaries.**
  - cfg_depth=0 → latency 1.
  - cfg_depth=31 → latency 16.
  - skew=1 with D=16 → lane 3 latency 19.
- **Async reset mid-stream.** Assert reset between edges with the pipeline full → outputs go to 0 immediately. After release, cfg D=1, skew=0 is in effect.
